// File: rtl/decoder_nx2n_seq_if.sv
// Load/scan/output bundle for decoder_nx2n_seq.
// Optional macro DEC_ACTIVE_LOW_EN adds the active-low mirror output out_n.
interface decoder_nx2n_seq_if #(
  parameter int unsigned N = 3
);
  localparam int unsigned W = 1 << N;

  logic         en;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_sel;
  logic         scan_start;
  logic         scan_stop;
  logic         scan_busy;
  logic         done;
  logic [W-1:0] out;
  logic         out_valid;
`ifdef DEC_ACTIVE_LOW_EN
  logic [W-1:0] out_n;
`endif

`ifdef DEC_ACTIVE_LOW_EN
  modport master (
    output en, in_valid, in_sel, scan_start, scan_stop,
    input  in_ready, scan_busy, done, out, out_valid, out_n
  );
  modport slave (
    input  en, in_valid, in_sel, scan_start, scan_stop,
    output in_ready, scan_busy, done, out, out_valid, out_n
  );
`else
  modport master (
    output en, in_valid, in_sel, scan_start, scan_stop,
    input  in_ready, scan_busy, done, out, out_valid
  );
  modport slave (
    input  en, in_valid, in_sel, scan_start, scan_stop,
    output in_ready, scan_busy, done, out, out_valid
  );
`endif
endinterface

// File: rtl/decoder_nx2n_seq.sv
// N-to-2^N one-hot decoder with registered output, valid/ready load port
// and a scan sequencer that walks the one-hot code across every line.
// Optional macro DEC_ACTIVE_LOW_EN adds registered out_n = ~out (resets to all-ones).
module decoder_nx2n_seq #(
  parameter int unsigned N     = 3,
  parameter int unsigned DWELL = 4,
  parameter bit          WRAP  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  decoder_nx2n_seq_if.slave bus
);
  localparam int unsigned W  = 1 << N;
  localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic {
    S_DIRECT = 1'b0,
    S_SCAN   = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  idx_q, idx_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [W-1:0]  out_q, out_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [N-1:0]  idx_inc;
  logic          dwell_end;
  logic          last_idx;
`ifdef DEC_ACTIVE_LOW_EN
  logic [W-1:0]  out_n_q;
`endif

  assign idx_inc   = idx_q + N'(1);
  assign dwell_end = (dwell_q == DW'(DWELL - 1));
  assign last_idx  = (idx_q == {N{1'b1}});

  // Loads are accepted only in DIRECT, and a pending scan start takes precedence.
  assign bus.in_ready = bus.en & (state_q == S_DIRECT) & ~bus.scan_start;

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_DIRECT;
      idx_q       <= '0;
      dwell_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dwell_q     <= dwell_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef DEC_ACTIVE_LOW_EN
  // Active-low mirror, loaded on the same edge as out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_n_q <= '1;
    end else begin
      out_n_q <= ~out_d;
    end
  end

  assign bus.out_n = out_n_q;
`endif

  // Next-state and next-output logic; en low overrides everything.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dwell_d     = dwell_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    if (!bus.en) begin
      state_d     = S_DIRECT;
      idx_d       = '0;
      dwell_d     = '0;
      out_d       = '0;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        S_DIRECT: begin
          if (bus.scan_start) begin
            state_d     = S_SCAN;
            idx_d       = '0;
            dwell_d     = '0;
            out_d       = W'(1);
            out_valid_d = 1'b1;
            busy_d      = 1'b1;
          end else if (bus.in_valid) begin
            out_d       = W'(1) << bus.in_sel;
            out_valid_d = 1'b1;
          end
        end
        S_SCAN: begin
          if (bus.scan_stop) begin
            state_d     = S_DIRECT;
            idx_d       = '0;
            dwell_d     = '0;
            out_d       = '0;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
          end else if (!dwell_end) begin
            dwell_d = dwell_q + DW'(1);
          end else if (!last_idx) begin
            dwell_d = '0;
            idx_d   = idx_inc;
            out_d   = W'(1) << idx_inc;
          end else if (WRAP) begin
            dwell_d = '0;
            idx_d   = '0;
            out_d   = W'(1);
          end else begin
            state_d     = S_DIRECT;
            idx_d       = '0;
            dwell_d     = '0;
            out_d       = '0;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end
        end
        default: begin
          state_d     = S_DIRECT;
          idx_d       = '0;
          dwell_d     = '0;
          out_d       = '0;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      endcase
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.scan_busy = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_decoder_nx2n_seq.sv
// Bench for decoder_nx2n_seq: two instances (single-pass and wrapping scan)
// share stimulus and are compared against a cycle-position reference model.
module tb_decoder_nx2n_seq;
  localparam int unsigned N     = 3;
  localparam int unsigned DWELL = 2;
  localparam int unsigned LINES = 1 << N;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  decoder_nx2n_seq_if #(.N(N)) if0 ();
  decoder_nx2n_seq_if #(.N(N)) if1 ();

  decoder_nx2n_seq #(.N(N), .DWELL(DWELL), .WRAP(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );
  decoder_nx2n_seq #(.N(N), .DWELL(DWELL), .WRAP(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: scan progress is a plain elapsed-cycle count.
  bit       m_scan [2];
  int       m_t    [2];
  logic [7:0] m_dir [2];
  bit       m_vld  [2];
  bit       m_done [2];

  function automatic logic [7:0] exp_out(input int i);
    logic [7:0] one;
    one = 8'h01;
    return m_scan[i] ? (one << (m_t[i] / DWELL)) : m_dir[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_scan[i] = 0; m_t[i] = 0; m_dir[i] = '0; m_vld[i] = 0; m_done[i] = 0;
    end
  endtask

  task automatic model_step(input bit e, input bit v, input logic [2:0] s,
                            input bit st, input bit sp);
    logic [7:0] one;
    one = 8'h01;
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 0;
      if (!e) begin
        m_scan[i] = 0; m_dir[i] = '0; m_vld[i] = 0;
      end else if (!m_scan[i]) begin
        if (st) begin
          m_scan[i] = 1; m_t[i] = 0; m_dir[i] = '0; m_vld[i] = 0;
        end else if (v) begin
          m_dir[i] = one << s; m_vld[i] = 1;
        end
      end else if (sp) begin
        m_scan[i] = 0; m_dir[i] = '0; m_vld[i] = 0;
      end else begin
        m_t[i]++;
        if (m_t[i] == int'(LINES * DWELL)) begin
          if (i == 1) begin
            m_t[i] = 0;
          end else begin
            m_scan[i] = 0; m_dir[i] = '0; m_vld[i] = 0; m_done[i] = 1;
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [7:0] o;
    for (int i = 0; i < 2; i++) begin
      o = (i == 0) ? if0.out : if1.out;
      chk($sformatf("out[%0d]", i), 64'(o), 64'(exp_out(i)));
      chk($sformatf("out_valid[%0d]", i), 64'((i == 0) ? if0.out_valid : if1.out_valid),
          64'(m_scan[i] | m_vld[i]));
      chk($sformatf("scan_busy[%0d]", i), 64'((i == 0) ? if0.scan_busy : if1.scan_busy),
          64'(m_scan[i]));
      chk($sformatf("done[%0d]", i), 64'((i == 0) ? if0.done : if1.done), 64'(m_done[i]));
      chk($sformatf("onehot[%0d]", i), 64'($countones(o) <= 1), 64'(1));
`ifdef DEC_ACTIVE_LOW_EN
      chk($sformatf("out_n[%0d]", i), 64'((i == 0) ? if0.out_n : if1.out_n),
          64'(~exp_out(i)));
`endif
    end
  endtask

  // One clock: drive after the falling edge, check ready, clock, check outputs.
  task automatic cyc(input bit e, input bit v, input logic [2:0] s,
                     input bit st, input bit sp);
    if0.en = e; if0.in_valid = v; if0.in_sel = s; if0.scan_start = st; if0.scan_stop = sp;
    if1.en = e; if1.in_valid = v; if1.in_sel = s; if1.scan_start = st; if1.scan_stop = sp;
    #1;
    chk("in_ready[0]", 64'(if0.in_ready), 64'(e & ~m_scan[0] & ~st));
    chk("in_ready[1]", 64'(if1.in_ready), 64'(e & ~m_scan[1] & ~st));
    model_step(e, v, s, st, sp);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    model_reset();
    if0.en = 0; if0.in_valid = 0; if0.in_sel = '0; if0.scan_start = 0; if0.scan_stop = 0;
    if1.en = 0; if1.in_valid = 0; if1.in_sel = '0; if1.scan_start = 0; if1.scan_stop = 0;
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Single load and back-to-back loads.
    cyc(1, 1, 3'b101, 0, 0);
    chk("load_101", 64'(if0.out), 64'h20);
    cyc(1, 1, 3'b000, 0, 0);
    chk("b2b_000", 64'(if0.out), 64'h01);
    cyc(1, 1, 3'b111, 0, 0);
    chk("b2b_111", 64'(if0.out), 64'h80);
    cyc(1, 1, 3'b011, 0, 0);
    chk("b2b_011", 64'(if0.out), 64'h08);
    cyc(1, 0, 3'b000, 0, 0);

    // Full scan pass: single-pass instance finishes, wrapping one restarts.
    cyc(1, 0, 3'b000, 1, 0);
    repeat (LINES * DWELL) cyc(1, 0, 3'b000, 0, 0);
    chk("scan_done", 64'(if0.done), 64'h1);
    chk("scan_end_out", 64'(if0.out), 64'h00);
    chk("wrap_out", 64'(if1.out), 64'h01);
    cyc(1, 1, 3'b001, 1, 0);
    chk("done_pulse_once", 64'(if0.done), 64'h0);

    // Stop at index 5: no done pulse.
    cyc(1, 0, 3'b000, 0, 1);
    cyc(1, 0, 3'b000, 1, 0);
    repeat (5 * DWELL) cyc(1, 0, 3'b000, 0, 0);
    chk("at_idx5", 64'(if0.out), 64'h20);
    cyc(1, 0, 3'b000, 0, 1);
    chk("stop_out", 64'(if1.out), 64'h00);
    chk("stop_nodone", 64'(if0.done), 64'h0);

    // Start wins over a same-cycle load; en low mid-scan clears.
    cyc(1, 1, 3'b010, 1, 0);
    chk("start_wins", 64'(if0.out), 64'h01);
    repeat (3) cyc(1, 1, 3'b110, 0, 0);
    cyc(0, 0, 3'b000, 0, 0);
    chk("en_low_out", 64'(if1.out), 64'h00);

    // Asynchronous reset in the middle of a dwell.
    cyc(1, 0, 3'b000, 1, 0);
    cyc(1, 0, 3'b000, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out", 64'(if0.out), 64'h00);
    chk("arst_valid", 64'(if1.out_valid), 64'h0);
    chk("arst_busy", 64'(if1.scan_busy), 64'h0);
`ifdef DEC_ACTIVE_LOW_EN
    chk("arst_out_n", 64'(if0.out_n), 64'hFF);
`endif
    model_reset();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      cyc(($urandom_range(0, 99) < 96), $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
          ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
